// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR / trap block: CSR addresses,
// mstatus bit positions, the external-interrupt cause code and the PC-select encoding.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;

    localparam logic [31:0] MCAUSE_EXT_IRQ = 32'h8000_000B;

    typedef enum logic [2:0] {
        PC_PLUS4  = 3'd0,
        PC_JALR   = 3'd1,
        PC_BRANCH = 3'd2,
        PC_JAL    = 3'd3,
        PC_MTVEC  = 3'd4,
        PC_MEPC   = 3'd5
    } pc_sel_t;

    typedef enum logic {
        IRQ_IDLE = 1'b0,
        IRQ_PEND = 1'b1
    } irq_state_t;

    function automatic logic [31:0] align4(input logic [31:0] v);
        return {v[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/csr_trap_unit_irq_sync.sv
// External interrupt front end: optional 2-flop synchronizer (IRQ_SYNC_EN)
// followed by a rising-edge detector producing a one-cycle irq_edge pulse.
module irq_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic irq,
    output logic irq_edge
);

    logic irq_s;
    logic irq_p2;

`ifdef IRQ_SYNC_EN
    logic sync_p0;
    logic sync_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= irq;
            sync_p1 <= sync_p0;
        end
    end

    assign irq_s = sync_p1;
`else
    assign irq_s = irq;
`endif

    // edge register: previous value of the (synchronized) request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_p2 <= 1'b0;
        end else begin
            irq_p2 <= irq_s;
        end
    end

    assign irq_edge = irq_s & ~irq_p2;

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSRs (mstatus/mtvec/mepc/mcause), external interrupt latch and
// trap entry / mret sequencing with next-PC select override. Option: IRQ_SYNC_EN.
module csr_trap_unit
    import csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        irq,
    input  logic        commit,
    input  logic [31:0] pc_next,
    input  logic [2:0]  pc_sel_dec,
    input  logic        mret,
    input  logic        csr_we,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wd,
    output logic [31:0] csr_rd,
    output logic [2:0]  pc_sel,
    output logic [31:0] mtvec,
    output logic [31:0] mepc,
    output logic        int_taken
);

    irq_state_t  state;
    irq_state_t  state_nxt;
    logic        irq_edge;
    logic        mie;
    logic        mpie;
    logic [31:0] mcause;
    logic        trap;
    logic        ret;
    logic        csr_wr;

    irq_sync u_irq_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .irq      (irq),
        .irq_edge (irq_edge)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IRQ_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        trap      = commit && (state == IRQ_PEND) && mie && !mret;
        ret       = commit && mret;
        csr_wr    = commit && csr_we;
        pc_sel    = pc_sel_dec[2] ? PC_PLUS4 : pc_sel_dec;
        case (state)
            IRQ_IDLE: if (irq_edge) state_nxt = IRQ_PEND;
            IRQ_PEND: if (trap)     state_nxt = IRQ_IDLE;
            default:                state_nxt = IRQ_IDLE;
        endcase
        // mret has already excluded trap, so the two overrides never collide
        if (trap) begin
            pc_sel = PC_MTVEC;
        end else if (ret) begin
            pc_sel = PC_MEPC;
        end
    end

    assign int_taken = trap;

    // Trap entry outranks software writes to mstatus/mepc/mcause; mtvec is never touched by the trap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtvec  <= MTVEC_RESET;
            mepc   <= 32'h0;
            mcause <= 32'h0;
            mie    <= 1'b0;
            mpie   <= 1'b0;
        end else begin
            if (csr_wr && csr_addr == CSR_MTVEC) begin
                mtvec <= align4(csr_wd);
            end

            if (trap) begin
                mpie <= mie;
                mie  <= 1'b0;
            end else if (ret) begin
                mie  <= mpie;
                mpie <= 1'b1;
            end else if (csr_wr && csr_addr == CSR_MSTATUS) begin
                mie  <= csr_wd[MSTATUS_MIE_BIT];
                mpie <= csr_wd[MSTATUS_MPIE_BIT];
            end

            if (trap) begin
                mepc <= pc_next;
            end else if (csr_wr && csr_addr == CSR_MEPC) begin
                mepc <= align4(csr_wd);
            end

            if (trap) begin
                mcause <= MCAUSE_EXT_IRQ;
            end else if (csr_wr && csr_addr == CSR_MCAUSE) begin
                mcause <= csr_wd;
            end
        end
    end

    always_comb begin
        csr_rd = 32'h0;
        case (csr_addr)
            CSR_MSTATUS: begin
                csr_rd[MSTATUS_MIE_BIT]  = mie;
                csr_rd[MSTATUS_MPIE_BIT] = mpie;
            end
            CSR_MTVEC:   csr_rd = mtvec;
            CSR_MEPC:    csr_rd = mepc;
            CSR_MCAUSE:  csr_rd = mcause;
            default:     csr_rd = 32'h0;
        endcase
    end

endmodule
